// File: rtl/buffer_reader_vga_pkg.sv
// Shared definitions for the frame-buffer read side: 640x480@60 default timing,
// total-period derivation and the stage-1 control bundle. The capture-side
// modules import the same timing constants.
package buffer_reader_vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Full period of one axis: visible + front porch + sync + back porch.
  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int VGA_H_TOTAL = vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL = vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

  // Per-pixel control decoded from the raster position; travels with the RAM read.
  typedef struct packed {
    logic act;
    logic win;
    logic hs_n;
    logic vs_n;
    logic fs;
  } ctl_t;

  // Idle value: syncs deasserted (high), nothing visible, no frame pulse.
  localparam ctl_t CTL_IDLE = '{act: 1'b0, win: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus the position decodes (active area, sync pulses, frame start).
// The counters stay parked at (0,0) on the first edge after reset so that the
// first frame starts cleanly one cycle after release.
module vga_timing_gen
  import buffer_reader_vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HCW      = $clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VCW      = $clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           run,
  output logic [HCW-1:0] hc,
  output logic [VCW-1:0] vc,
  output logic           act,
  output logic           hs_n,
  output logic           vs_n,
  output logic           fs
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACTIVE);
  localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VCW-1:0] VS_BEG   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic           run_q, run_d;

  // Next raster position: advance hc, carry into vc at end of line, wrap at end of frame.
  always_comb begin
    hc_d  = hc_q;
    vc_d  = vc_q;
    run_d = 1'b1;
    if (run_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + VCW'(1);
      end else begin
        hc_d = hc_q + HCW'(1);
      end
    end
  end

  // Counter state; reset returns the raster to the top-left and parks it for one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hc_q  <= '0;
      vc_q  <= '0;
      run_q <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      run_q <= run_d;
    end
  end

  // Position decodes; all forced idle while the raster is parked.
  always_comb begin
    act  = run_q && (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
    hs_n = !(run_q && (hc_q >= HS_BEG) && (hc_q <= HS_END));
    vs_n = !(run_q && (vc_q >= VS_BEG) && (vc_q <= VS_END));
    fs   = run_q && (hc_q == '0) && (vc_q == '0);
  end

  assign run = run_q;
  assign hc  = hc_q;
  assign vc  = vc_q;

endmodule

// File: rtl/buffer_reader_vga.sv
// Frame-buffer read client: scans the VGA raster, issues buffer reads for the
// image window at the top-left of the screen and presents pixels with sync and
// data-enable, all delayed by the same two clocks.
module buffer_reader_vga
  import buffer_reader_vga_pkg::*;
#(
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] addr_out,
  input  logic [DW-1:0] data_in,
  input  logic          blank,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [DW-1:0] rgb,
  output logic          frame_start
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST  = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] IMG_W_C = HCW'(IMG_W);
  localparam logic [VCW-1:0] IMG_H_C = VCW'(IMG_H);

  if (IMG_W > H_ACTIVE) begin : g_bad_img_w
    $error("buffer_reader_vga: IMG_W (%0d) exceeds H_ACTIVE (%0d)", IMG_W, H_ACTIVE);
  end
  if (IMG_H > V_ACTIVE) begin : g_bad_img_h
    $error("buffer_reader_vga: IMG_H (%0d) exceeds V_ACTIVE (%0d)", IMG_H, V_ACTIVE);
  end
  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << AW)) begin : g_bad_aw
    $error("buffer_reader_vga: IMG_W*IMG_H does not fit in AW=%0d address bits", AW);
  end

  logic           run;
  logic [HCW-1:0] hc;
  logic [VCW-1:0] vc;
  logic           act, hs_n, vs_n, fs;
  logic           win, frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HCW      (HCW),
    .VCW      (VCW)
  ) u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .hc    (hc),
    .vc    (vc),
    .act   (act),
    .hs_n  (hs_n),
    .vs_n  (vs_n),
    .fs    (fs)
  );

  logic [AW-1:0] addr_q, addr_d;
  ctl_t          ctl_p1_q, ctl_p1_d;
  logic [DW-1:0] rgb_p2_q, rgb_p2_d;
  logic          hs_n_p2_q, hs_n_p2_d;
  logic          vs_n_p2_q, vs_n_p2_d;
  logic          de_p2_q, de_p2_d;
  logic          fs_p2_q, fs_p2_d;

  // Image window and end-of-frame detection from the current raster position.
  always_comb begin
    win       = run && (hc < IMG_W_C) && (vc < IMG_H_C);
    frame_end = (hc == H_LAST) && (vc == V_LAST);
  end

  // Read address tracks the window pixel index; frame wrap beats the increment.
  always_comb begin
    addr_d = addr_q;
    if (frame_end) begin
      addr_d = '0;
    end else if (win) begin
      addr_d = addr_q + AW'(1);
    end
  end

  // ---- stage 0 -> stage 1: control captured while the RAM read is in flight ----
  always_comb begin
    ctl_p1_d = '{act: act, win: win, hs_n: hs_n, vs_n: vs_n, fs: fs};
  end

  // ---- stage 1 -> stage 2: pixel mux (window, blank) and registered outputs ----
  always_comb begin
    rgb_p2_d  = (ctl_p1_q.win && !blank) ? data_in : '0;
    hs_n_p2_d = ctl_p1_q.hs_n;
    vs_n_p2_d = ctl_p1_q.vs_n;
    de_p2_d   = ctl_p1_q.act;
    fs_p2_d   = ctl_p1_q.fs;
  end

  // Address counter and both pipeline stages; reset clears everything to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      ctl_p1_q  <= CTL_IDLE;
      rgb_p2_q  <= '0;
      hs_n_p2_q <= 1'b1;
      vs_n_p2_q <= 1'b1;
      de_p2_q   <= 1'b0;
      fs_p2_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      ctl_p1_q  <= ctl_p1_d;
      rgb_p2_q  <= rgb_p2_d;
      hs_n_p2_q <= hs_n_p2_d;
      vs_n_p2_q <= vs_n_p2_d;
      de_p2_q   <= de_p2_d;
      fs_p2_q   <= fs_p2_d;
    end
  end

  assign addr_out    = addr_q;
  assign rgb         = rgb_p2_q;
  assign hsync       = hs_n_p2_q;
  assign vsync       = vs_n_p2_q;
  assign de          = de_p2_q;
  assign frame_start = fs_p2_q;

endmodule

// File: tb/tb_buffer_reader_vga.sv
// Scoreboard bench for buffer_reader_vga. Two instances on a reduced raster:
// a small image window (16x12) and a full-screen window. Expected outputs come
// from a position-arithmetic model of the raster; a monitor pops and compares.
module tb_buffer_reader_vga;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int A_IW = 16, A_IH = 12, A_AW = 8;
  localparam int B_IW = HA, B_IH = VA, B_AW = 12;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [7:0] rgb;
    int         addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic blank = 1'b0;

  logic [A_AW-1:0] addr_a;
  logic [B_AW-1:0] addr_b;
  logic [7:0]      data_a, data_b, rgb_a, rgb_b;
  logic            hs_a, vs_a, de_a, fs_a;
  logic            hs_b, vs_b, de_b, fs_b;

  logic [7:0] mem_a [0:(1<<A_AW)-1];
  logic [7:0] mem_b [0:(1<<B_AW)-1];

  exp_t q_a[$];
  exp_t q_b[$];

  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;
  int c_cnt = 0;        // active edges since reset release (0 = release edge)
  int neg_cycle = 0;
  int last_fs = -1;
  int period_checks = 0;
  int burst = 0;

  always #5 clk = ~clk;

  buffer_reader_vga #(
    .AW(A_AW), .DW(8), .IMG_W(A_IW), .IMG_H(A_IH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .addr_out(addr_a), .data_in(data_a), .blank(blank),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a), .frame_start(fs_a)
  );

  buffer_reader_vga #(
    .AW(B_AW), .DW(8), .IMG_W(B_IW), .IMG_H(B_IH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .addr_out(addr_b), .data_in(data_b), .blank(blank),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b), .frame_start(fs_b)
  );

  // Frame buffer models: one-cycle registered read.
  always @(posedge clk) begin
    data_a <= mem_a[addr_a];
    data_b <= mem_b[addr_b];
  end

  // Expected state after active edge number c since release.
  function automatic exp_t ref_model(input int c, input bit in_rst, input int iw, input int ih,
                                     input bit blk, input bit use_b);
    exp_t e;
    int q, qx, qy, p, x, y;
    e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, rgb: 8'h00, addr: 0};
    if (in_rst) return e;
    q  = c % FT;
    qx = q % HT;
    qy = q / HT;
    e.addr = ((qy < ih) ? qy : ih) * iw + ((qy < ih) ? ((qx < iw) ? qx : iw) : 0);
    if (c >= 2) begin
      p = (c - 2) % FT;
      x = p % HT;
      y = p / HT;
      e.de = (x < HA) && (y < VA);
      e.hs = !((x >= HA + HFP) && (x < HA + HFP + HS));
      e.vs = !((y >= VA + VFP) && (y < VA + VFP + VS));
      e.fs = (p == 0);
      if (x < iw && y < ih && !blk)
        e.rgb = use_b ? mem_b[y*iw + x] : mem_a[y*iw + x];
    end
    return e;
  endfunction

  // Stimulus side of the scoreboard: push expectations for every active edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      q_a.push_back(ref_model(0, 1'b1, A_IW, A_IH, blank, 1'b0));
      q_b.push_back(ref_model(0, 1'b1, B_IW, B_IH, blank, 1'b1));
      c_cnt = 0;
    end else begin
      q_a.push_back(ref_model(c_cnt, 1'b0, A_IW, A_IH, blank, 1'b0));
      q_b.push_back(ref_model(c_cnt, 1'b0, B_IW, B_IH, blank, 1'b1));
      c_cnt = c_cnt + 1;
    end
  end

  task automatic check(input string nm, input bit have, input exp_t e,
                       input logic hs, input logic vs, input logic de, input logic fs,
                       input logic [7:0] rgb, input logic [31:0] addr);
    vectors++;
    if (!have) begin
      miscompares++;
      if (fail_prints < 30) begin
        fail_prints++;
        $display("FAIL %s scoreboard empty at cycle %0d: got output with no expectation", nm, neg_cycle);
      end
    end else if (hs !== e.hs || vs !== e.vs || de !== e.de || fs !== e.fs ||
                 rgb !== e.rgb || addr !== 32'(e.addr)) begin
      miscompares++;
      if (fail_prints < 30) begin
        fail_prints++;
        $display("FAIL %s cycle %0d: got hs=%b vs=%b de=%b fs=%b rgb=%h addr=%0d, expected hs=%b vs=%b de=%b fs=%b rgb=%h addr=%0d",
                 nm, neg_cycle, hs, vs, de, fs, rgb, addr, e.hs, e.vs, e.de, e.fs, e.rgb, e.addr);
      end
    end
  endtask

  // Monitor: pop and compare every cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t ea, eb;
    bit   ha, hb;
    neg_cycle++;
    ha = (q_a.size() > 0);
    hb = (q_b.size() > 0);
    ea = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, rgb: 8'h00, addr: 0};
    eb = ea;
    if (ha) ea = q_a.pop_front();
    if (hb) eb = q_b.pop_front();
    check("win16x12", ha, ea, hs_a, vs_a, de_a, fs_a, rgb_a, 32'(addr_a));
    check("fullscr", hb, eb, hs_b, vs_b, de_b, fs_b, rgb_b, 32'(addr_b));
    // Frame period between frame_start pulses with no reset in between.
    if (!rst_n) begin
      last_fs = -1;
    end else if (fs_a === 1'b1) begin
      if (last_fs >= 0) begin
        vectors++;
        period_checks++;
        if (neg_cycle - last_fs != FT) begin
          miscompares++;
          $display("FAIL frame_period: got %0d clocks, expected %0d", neg_cycle - last_fs, FT);
        end
      end
      last_fs = neg_cycle;
    end
  end

  // One clock of stimulus: random blank bursts driven away from the active edge.
  task automatic step();
    @(negedge clk);
    if (burst > 0) begin
      blank = 1'b1;
      burst--;
    end else begin
      blank = 1'b0;
      if ($urandom_range(0, 59) == 0) burst = $urandom_range(1, 12);
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < (1 << A_AW); i++) mem_a[i] = 8'(i);
    for (int i = 0; i < (1 << B_AW); i++) mem_b[i] = 8'($urandom);

    rst_n = 1'b0;
    repeat (4) step();
    rst_n = 1'b1;
    repeat (2 * FT + 500) step();

    // Reset mid-frame at line 30, pixel 40 of the counter.
    found = 1'b0;
    for (int n = 0; n < FT + 10 && !found; n++) begin
      if ((c_cnt % FT) == 30 * HT + 40) found = 1'b1;
      else step();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midframe_wait: raster position 30/40 not reached within %0d clocks", FT + 10);
    end
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2 * FT + 100) step();
    @(negedge clk);

    vectors++;
    if (period_checks < 2) begin
      miscompares++;
      $display("FAIL frame_start_count: got %0d full periods, expected at least 2", period_checks);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
